lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 21 ++
 rtl/lsu.sv | 167 ++++++++++++++++
 tb/tb_lsu.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Memory-side bus of the load/store unit: one request strobe held until
// the memory returns a single-cycle ack with the raw read word.
interface lsu_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: accepts one core request at a time, places store
// data on byte lanes, formats load data and bounds memory waits with a timeout.
module lsu #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        rsp_valid,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        fault,
   lsu_if.master       bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t             state;
   state_t             next_state;

   logic               we_q;
   logic [2:0]         funct3_q;
   logic [31:0]        addr_q;
   logic [31:0]        wdata_q;
   logic [31:0]        rdata_q;
   logic               misalign_q;
   logic               fault_q;
   logic [CNT_W-1:0]   wait_cnt;

   logic               req_illegal;
   logic               req_unaligned;
   logic               req_bad;
   logic               timeout;
   logic [31:0]        lane_shifted;
   logic [15:0]        half_sel;
   logic [31:0]        load_data;
   logic [3:0]         store_be;
   logic [31:0]        store_data;

   // Bad requests never reach memory; they are answered straight from IDLE.
   always_comb begin
      if (req_we) begin
         req_illegal = (funct3 >= 3'b011);
      end else begin
         req_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      req_unaligned = ((funct3[1:0] == 2'b01) && addr[0])
                   || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      req_bad = req_illegal || req_unaligned;
   end

   assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      lane_shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};
      half_sel     = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (funct3_q)
         3'b000:  load_data = {{24{lane_shifted[7]}}, lane_shifted[7:0]};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_data = {24'h000000, lane_shifted[7:0]};
         3'b101:  load_data = {16'h0000, half_sel};
         default: load_data = bus.mem_rdata;
      endcase
   end

   // Narrow stores replicate their data so every enabled lane sees it.
   always_comb begin
      case (funct3_q[1:0])
         2'b00: begin
            store_be   = 4'b0001 << addr_q[1:0];
            store_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            store_be   = addr_q[1] ? 4'b1100 : 4'b0011;
            store_data = {2{wdata_q[15:0]}};
         end
         default: begin
            store_be   = 4'b1111;
            store_data = wdata_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req_valid) next_state = req_bad ? RESP : ACCESS;
         ACCESS:  if (bus.mem_ack || timeout) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request capture, wait counting and response registers; ack takes
   // priority over a timeout landing in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q       <= 1'b0;
         funct3_q   <= 3'b000;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         rdata_q    <= 32'h0;
         misalign_q <= 1'b0;
         fault_q    <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  we_q       <= req_we;
                  funct3_q   <= funct3;
                  addr_q     <= addr;
                  wdata_q    <= wdata;
                  misalign_q <= req_bad;
                  fault_q    <= 1'b0;
                  rdata_q    <= 32'h0;
                  wait_cnt   <= '0;
               end
            end
            ACCESS: begin
               if (bus.mem_ack) begin
                  if (!we_q) rdata_q <= load_data;
               end else if (timeout) begin
                  fault_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      req_ready     = (state == IDLE);
      rsp_valid     = (state == RESP);
      misalign      = (state == RESP) && misalign_q;
      fault         = (state == RESP) && fault_q;
      rdata         = (state == RESP) ? rdata_q : 32'h0;
      bus.mem_req   = (state == ACCESS);
      bus.mem_we    = (state == ACCESS) && we_q;
      bus.mem_be    = ((state == ACCESS) && we_q) ? store_be : 4'b0000;
      bus.mem_addr  = {addr_q[31:2], 2'b00};
      bus.mem_wdata = store_data;
   end

endmodule

// File: tb/tb_lsu.sv
// Scoreboarded bench for the load/store unit; a small memory responder acks
// after a chosen number of ACCESS cycles, or never to provoke a timeout.
module tb_lsu;

   localparam int TIMEOUT = 15;

   typedef struct packed {
      logic [31:0] rdata;
      logic        misalign;
      logic        fault;
      logic [31:0] lat;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rsp_valid;
   logic [31:0] rdata;
   logic        misalign;
   logic        fault;

   int vectors;
   int miscompares;
   exp_t exp_q[$];

   lsu_if bus ();

   lsu #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .rsp_valid (rsp_valid),
      .rdata     (rdata),
      .misalign  (misalign),
      .fault     (fault),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   function automatic logic model_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'b000:  return 1'b0;
         3'b001:  return a[0];
         3'b010:  return a[1] | a[0];
         3'b100:  return we;
         3'b101:  return we | a[0];
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[a[1:0]*8 +: 8];
      h = word[a[1]*16 +: 16];
      case (f3)
         3'b000:  return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
         3'b001:  return h[15] ? {16'hFFFF, h} : {16'h0, h};
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
      if (!we) return 4'b0000;
      case (f3)
         3'b000:  return 4'b0001 << a[1:0];
         3'b001:  return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (f3)
         3'b000:  return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
         3'b001:  return {wd[15:0], wd[15:0]};
         default: return wd;
      endcase
   endfunction

   // ack_at: ACCESS cycle (1-based) in which memory acks; 0 means never.
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input int ack_at, input logic [31:0] word);
      exp_t e;
      exp_t got;
      logic bad;
      int   access_cycles;
      bit   done;
      bad = model_bad(we, f3, a);
      e.misalign = bad;
      if (bad) begin
         e.rdata = 32'h0; e.fault = 1'b0; e.lat = 0;
      end else if (ack_at == 0 || ack_at > TIMEOUT) begin
         e.rdata = 32'h0; e.fault = 1'b1; e.lat = TIMEOUT;
      end else begin
         e.rdata = we ? 32'h0 : model_load(f3, a, word);
         e.fault = 1'b0; e.lat = ack_at;
      end

      @(negedge clk);
      checkOutput("req_ready", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
      @(posedge clk);
      exp_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
      access_cycles = 0;
      done = 0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (rsp_valid) begin
            bus.mem_ack = 1'b0;
            checkOutput("rsp_mem_req", {31'h0, bus.mem_req}, 32'h0);
            checkOutput("latency", cyc, e.lat);
            if (exp_q.size() == 0) begin
               checkOutput("sb_empty", 32'h1, 32'h0);
            end else begin
               got = exp_q.pop_front();
               checkOutput("rdata", rdata, got.rdata);
               checkOutput("misalign", {31'h0, misalign}, {31'h0, got.misalign});
               checkOutput("fault", {31'h0, fault}, {31'h0, got.fault});
            end
            done = 1;
         end else if (bus.mem_req) begin
            access_cycles++;
            checkOutput("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
            checkOutput("mem_we", {31'h0, bus.mem_we}, {31'h0, we});
            checkOutput("mem_be", {28'h0, bus.mem_be}, {28'h0, model_be(we, f3, a)});
            if (we) checkOutput("mem_wdata", bus.mem_wdata, model_wdata(f3, wd));
            bus.mem_ack   = (access_cycles == ack_at);
            bus.mem_rdata = (access_cycles == ack_at) ? word : $urandom;
         end else begin
            checkOutput("stalled_no_req_no_rsp", 32'h0, 32'h1);
            done = 1;
         end
      end
      if (!done) checkOutput("rsp_wait_expired", 32'h0, 32'h1);
      if (bad) checkOutput("bad_no_access", access_cycles, 0);
      bus.mem_ack = 1'b0;
      @(negedge clk);
      checkOutput("rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000;
      addr = 32'h0; wdata = 32'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
      #3;
      checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      checkOutput("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
      checkOutput("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
      checkOutput("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
      checkOutput("rst_rdata", rdata, 32'h0);
      checkOutput("rst_flags", {30'h0, misalign, fault}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      applyStimulus(1'b0, 3'b010, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h80FF_FFFF);
      applyStimulus(1'b0, 3'b100, 32'h0000_0103, 32'h0, 2, 32'h80FF_FFFF);
      applyStimulus(1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 2, 32'h5555_5555);
      applyStimulus(1'b0, 3'b010, 32'h0000_0102, 32'h0, 1, 32'h1111_1111);
      applyStimulus(1'b0, 3'b010, 32'h0000_0200, 32'h0, 0, 32'h0);
      applyStimulus(1'b0, 3'b010, 32'h0000_0204, 32'h0, 15, 32'hCAFE_F00D);
      applyStimulus(1'b0, 3'b010, 32'h0000_0208, 32'h0, 14, 32'h0BAD_CAFE);
      applyStimulus(1'b0, 3'b001, 32'h0000_0102, 32'h0, 1, 32'h8001_1234);
      applyStimulus(1'b0, 3'b101, 32'h0000_0102, 32'h0, 1, 32'h8001_1234);
      applyStimulus(1'b0, 3'b001, 32'h0000_0100, 32'h0, 2, 32'h8001_9234);
      applyStimulus(1'b0, 3'b001, 32'h0000_0101, 32'h0, 1, 32'h0);
      applyStimulus(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 1, 32'h0);
      applyStimulus(1'b1, 3'b010, 32'h0000_0040, 32'h0102_0304, 3, 32'h0);
      applyStimulus(1'b1, 3'b010, 32'h0000_0041, 32'h0102_0304, 1, 32'h0);
      applyStimulus(1'b0, 3'b011, 32'h0000_0040, 32'h0, 1, 32'h0);
      applyStimulus(1'b1, 3'b100, 32'h0000_0040, 32'h0, 1, 32'h0);

      for (int i = 0; i < 12; i++) begin
         logic [2:0] f3;
         logic       we;
         we = 1'($urandom);
         f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
         applyStimulus(we, f3, $urandom, $urandom, $urandom_range(1, 5), $urandom);
      end

      // Reset while the memory is still being waited on.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("abort_pre_mem_req", {31'h0, bus.mem_req}, 32'h1);
      #2 rst = 1'b0;
      #1;
      checkOutput("abort_mem_req", {31'h0, bus.mem_req}, 32'h0);
      checkOutput("abort_req_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("abort_no_rsp", {31'h0, rsp_valid}, 32'h0);
      end
      applyStimulus(1'b0, 3'b010, 32'h0000_0300, 32'h0, 2, 32'h1357_9BDF);
      checkOutput("sb_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
